bm_il_fault_logger: RTL and testbench

Post-mortem recorder directly downstream of the BM position interlock stage. It consumes that stage's one-clock-delayed out-of-limit pulse (`il_sum`), the faulted-BPM address word (`il_address`) and the beam-dump flag (`err_flag`). Each fault is written as a frame-stamped entry into an internal FIFO. The block also latches the first fault since arming and freezes logging a programmable number of frames after a beam-dump decision, so software can read back which BPMs tripped and when.

---
 rtl/bm_il_fault_logger.sv | 188 ++++++++++++++++++
 tb/tb_bm_il_fault_logger.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bm_il_fault_logger.sv
// Post-mortem fault logger behind the BM position interlock: frame-stamped fault FIFO,
// first-fault capture and a post-dump freeze a programmable number of frames after err_flag.
module bm_il_fault_logger #(
  parameter int DEPTH       = 64,
  parameter int POST_FRAMES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   trig,
  input  logic                   il_sum,
  input  logic [14:0]            il_address,
  input  logic                   err_flag,
  input  logic                   arm,
  input  logic                   fifo_clr,
  input  logic                   rd_en,
  output logic [31:0]            rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic                   first_valid,
  output logic [14:0]            first_addr,
  output logic [16:0]            first_frame,
  output logic [2:0]             state,
  output logic [16:0]            frame_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_TRIPPED = 3'd2,
    S_POST    = 3'd3,
    S_FROZEN  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     post_q, post_d;
  logic           err_q;
  logic           first_valid_q, first_valid_d;
  logic [14:0]    first_addr_q, first_addr_d;
  logic [16:0]    first_frame_q, first_frame_d;
  logic           overflow_q, overflow_d;
  logic [15:0]    drop_q, drop_d;
  logic [16:0]    frame_q;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q, count_d;
  logic [31:0]    mem_q [DEPTH];
  logic [31:0]    rd_data_q;
  logic           rd_valid_q;
  logic           wr_req_s, pop_s, full_s, wr_acc_s, drop_s, err_rise_s;

  // count never exceeds DEPTH, so its MSB alone marks a full FIFO
  assign full_s     = count_q[AW];
  assign wr_req_s   = il_sum && !arm && (state_q inside {S_ARMED, S_TRIPPED, S_POST});
  assign pop_s      = rd_en && (count_q != '0) && !fifo_clr;
  assign wr_acc_s   = wr_req_s && !fifo_clr && (!full_s || pop_s);
  assign drop_s     = wr_req_s && !fifo_clr && full_s && !pop_s;
  assign err_rise_s = err_flag && !err_q;

  always_comb begin
    count_d = count_q;
    if (fifo_clr) begin
      count_d = '0;
    end else if (wr_acc_s && !pop_s) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_s && !wr_acc_s) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    post_d        = post_q;
    first_valid_d = first_valid_q;
    first_addr_d  = first_addr_q;
    first_frame_d = first_frame_q;
    overflow_d    = overflow_q || drop_s;
    drop_d        = (drop_s && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    if (wr_req_s && !first_valid_q) begin
      first_valid_d = 1'b1;
      first_addr_d  = il_address;
      first_frame_d = frame_q;
    end else begin
      first_valid_d = first_valid_q;
    end
    if (arm) begin
      state_d       = S_ARMED;
      post_d        = 8'd0;
      first_valid_d = 1'b0;
      first_addr_d  = 15'd0;
      first_frame_d = 17'd0;
      overflow_d    = 1'b0;
      drop_d        = 16'd0;
    end else begin
      case (state_q)
        S_IDLE:    state_d = S_IDLE;
        S_ARMED, S_TRIPPED: begin
          if (err_rise_s) begin
            state_d = S_POST;
            post_d  = 8'(POST_FRAMES);
          end else if (il_sum) begin
            state_d = S_TRIPPED;
          end else begin
            state_d = state_q;
          end
        end
        S_POST: begin
          if (trig && post_q == 8'd0) begin
            state_d = S_FROZEN;
          end else if (trig) begin
            post_d = post_q - 8'd1;
          end else begin
            state_d = S_POST;
          end
        end
        S_FROZEN:  state_d = S_FROZEN;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // err_q follows err_flag unconditionally, so a level already high at arm never reads as an edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      post_q        <= 8'd0;
      err_q         <= 1'b0;
      first_valid_q <= 1'b0;
      first_addr_q  <= 15'd0;
      first_frame_q <= 17'd0;
      overflow_q    <= 1'b0;
      drop_q        <= 16'd0;
      frame_q       <= 17'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_data_q     <= 32'd0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      post_q        <= post_d;
      err_q         <= err_flag;
      first_valid_q <= first_valid_d;
      first_addr_q  <= first_addr_d;
      first_frame_q <= first_frame_d;
      overflow_q    <= overflow_d;
      drop_q        <= drop_d;
      frame_q       <= trig ? frame_q + 17'd1 : frame_q;
      count_q       <= count_d;
      rd_valid_q    <= pop_s;
      if (pop_s) begin
        rd_data_q <= mem_q[rd_ptr_q];
      end
      if (fifo_clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_acc_s) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_s)    rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_acc_s) begin
      mem_q[wr_ptr_q] <= {frame_q, il_address};
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign fifo_count  = count_q;
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = full_s;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_q;
  assign first_valid = first_valid_q;
  assign first_addr  = first_addr_q;
  assign first_frame = first_frame_q;
  assign state       = state_q;
  assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_bm_il_fault_logger.sv
// Bench for bm_il_fault_logger: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized phase.
module tb_bm_il_fault_logger;
  localparam int DEPTH = 64;
  localparam int PF    = 2;

  logic        clk = 1'b0;
  logic        reset, trig, il_sum, err_flag, arm, fifo_clr, rd_en;
  logic [14:0] il_address;
  logic [31:0] rd_data;
  logic        rd_valid, fifo_empty, fifo_full, overflow, first_valid;
  logic [6:0]  fifo_count;
  logic [15:0] drop_cnt;
  logic [14:0] first_addr;
  logic [16:0] first_frame, frame_cnt;
  logic [2:0]  state;

  bm_il_fault_logger #(.DEPTH(DEPTH), .POST_FRAMES(PF)) dut (
    .clk(clk), .reset(reset), .trig(trig), .il_sum(il_sum), .il_address(il_address),
    .err_flag(err_flag), .arm(arm), .fifo_clr(fifo_clr), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow),
    .drop_cnt(drop_cnt), .first_valid(first_valid), .first_addr(first_addr),
    .first_frame(first_frame), .state(state), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, state as plain integers
  logic [31:0] q[$];
  int          m_state, m_post;
  logic [16:0] m_frame, m_first_frame;
  logic [14:0] m_first_addr;
  logic [31:0] m_rd_data;
  logic [15:0] m_drop;
  bit          m_rd_valid, m_overflow, m_first_valid, m_err_prev;

  always @(posedge clk) begin : model
    int sz;
    bit we, pop;
    if (!reset) begin
      q.delete();
      m_state = 0; m_post = 0; m_frame = '0; m_first_frame = '0; m_first_addr = '0;
      m_rd_data = '0; m_drop = '0; m_rd_valid = 0; m_overflow = 0; m_first_valid = 0;
      m_err_prev = 0;
    end else begin
      sz  = q.size();
      we  = il_sum && (m_state >= 1 && m_state <= 3) && !arm;
      pop = rd_en && (sz > 0) && !fifo_clr;
      m_rd_valid = pop;
      if (pop) m_rd_data = q[0];
      if (fifo_clr) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (we) begin
          if (sz < DEPTH || pop) q.push_back({m_frame, il_address});
          else begin
            m_overflow = 1;
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          end
        end
      end
      if (we && !m_first_valid) begin
        m_first_valid = 1; m_first_addr = il_address; m_first_frame = m_frame;
      end
      if (arm) begin
        m_state = 1; m_post = 0; m_first_valid = 0; m_first_addr = '0; m_first_frame = '0;
        m_overflow = 0; m_drop = '0;
      end else if ((m_state == 1 || m_state == 2) && err_flag && !m_err_prev) begin
        m_state = 3; m_post = PF;
      end else if (m_state == 1 && il_sum) begin
        m_state = 2;
      end else if (m_state == 3 && trig) begin
        if (m_post == 0) m_state = 4;
        else m_post = m_post - 1;
      end
      m_err_prev = err_flag;
      if (trig) m_frame = m_frame + 17'd1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state), 32'(m_state));
      chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
      chk("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
      chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      chk("rd_data", rd_data, m_rd_data);
      chk("overflow", 32'(overflow), 32'(m_overflow));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      chk("first_valid", 32'(first_valid), 32'(m_first_valid));
      chk("first_addr", 32'(first_addr), 32'(m_first_addr));
      chk("first_frame", 32'(first_frame), 32'(m_first_frame));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    trig = 1'b0; il_sum = 1'b0; arm = 1'b0; fifo_clr = 1'b0; rd_en = 1'b0;
  endtask

  task automatic sum(input logic [14:0] a);
    il_sum = 1'b1; il_address = a; tick();
  endtask

  initial begin
    reset = 1'b0; trig = 1'b0; il_sum = 1'b0; err_flag = 1'b0; arm = 1'b0;
    fifo_clr = 1'b0; rd_en = 1'b0; il_address = 15'd0;
    tick(); chk_en = 1'b1; tick();
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    reset = 1'b1;

    // First fault and ordering
    arm = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin trig = 1'b1; tick(); end
    sum(15'h0405); sum(15'h0812);
    @(negedge clk);
    chk("ff_state", 32'(state), 32'd2);
    chk("ff_addr", 32'(first_addr), 32'h0405);
    chk("ff_frame", 32'(first_frame), 32'd3);
    chk("ff_count", 32'(fifo_count), 32'd2);
    rd_en = 1'b1; tick(); @(negedge clk);
    chk("pop0", rd_data, 32'h0001_8405);
    rd_en = 1'b1; tick(); @(negedge clk);
    chk("pop1", rd_data, 32'h0001_8812);
    rd_en = 1'b1; tick(); @(negedge clk);
    chk("empty_rd_valid", 32'(rd_valid), 32'd0);
    chk("empty_rd_hold", rd_data, 32'h0001_8812);

    // Overflow
    for (int i = 0; i < 70; i++) sum(15'($urandom_range(0, 16383)));
    @(negedge clk);
    chk("ov_full", 32'(fifo_full), 32'd1);
    chk("ov_flag", 32'(overflow), 32'd1);
    chk("ov_drop", 32'(drop_cnt), 32'd6);
    il_sum = 1'b1; rd_en = 1'b1; il_address = 15'h1234; tick(); @(negedge clk);
    chk("ov_rw_count", 32'(fifo_count), 32'd64);
    chk("ov_rw_drop", 32'(drop_cnt), 32'd6);
    for (int i = 0; i < 64; i++) begin rd_en = 1'b1; tick(); end
    @(negedge clk);
    chk("drained", 32'(fifo_empty), 32'd1);

    // Post-mortem freeze
    err_flag = 1'b1; tick(); @(negedge clk);
    chk("post_state", 32'(state), 32'd3);
    trig = 1'b1; tick();
    sum(15'h0123);
    @(negedge clk);
    chk("post_logged", 32'(fifo_count), 32'd1);
    trig = 1'b1; tick(); trig = 1'b1; tick(); @(negedge clk);
    chk("frozen_state", 32'(state), 32'd4);
    sum(15'h0777); @(negedge clk);
    chk("frozen_nolog", 32'(fifo_count), 32'd1);

    // Arm priority
    arm = 1'b1; il_sum = 1'b1; il_address = 15'h0055; tick(); @(negedge clk);
    chk("arm_state", 32'(state), 32'd1);
    chk("arm_fvalid", 32'(first_valid), 32'd0);
    chk("arm_ovf", 32'(overflow), 32'd0);
    chk("arm_count", 32'(fifo_count), 32'd1);
    sum(15'h0066); tick(); @(negedge clk);
    chk("rearm_trip", 32'(state), 32'd2);

    // Empty and clear
    sum(15'h0001); sum(15'h0002); sum(15'h0003);
    @(negedge clk);
    chk("clr_pre", 32'(fifo_count), 32'd5);
    fifo_clr = 1'b1; il_sum = 1'b1; rd_en = 1'b1; tick(); @(negedge clk);
    chk("clr_count", 32'(fifo_count), 32'd0);
    chk("clr_rdv", 32'(rd_valid), 32'd0);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 799) != 0);
      trig       = ($urandom_range(0, 5) == 0);
      il_sum     = ($urandom_range(0, 1) == 0);
      il_address = 15'($urandom_range(0, 16383));
      rd_en      = ($urandom_range(0, 2) == 0);
      arm        = ($urandom_range(0, 49) == 0);
      fifo_clr   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) err_flag = ~err_flag;
      tick();
    end
    reset = 1'b1;

    // Reset mid-POST
    err_flag = 1'b0; fifo_clr = 1'b1; tick();
    arm = 1'b1; tick();
    err_flag = 1'b1; tick(); @(negedge clk);
    chk("rp_post", 32'(state), 32'd3);
    sum(15'h0099);
    reset = 1'b0; tick(); reset = 1'b1; @(negedge clk);
    chk("rp_state", 32'(state), 32'd0);
    chk("rp_empty", 32'(fifo_empty), 32'd1);
    chk("rp_count", 32'(fifo_count), 32'd0);
    chk("rp_fvalid", 32'(first_valid), 32'd0);
    chk("rp_faddr", 32'(first_addr), 32'd0);
    chk("rp_frame", 32'(frame_cnt), 32'd0);
    chk("rp_rdata", rd_data, 32'd0);
    sum(15'h0011); @(negedge clk);
    chk("idle_nolog", 32'(fifo_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
